// File: rtl/gpr_wb_ctrl_pkg.sv
// Shared types and constants for the GPR write-back controller.
package gpr_wb_ctrl_pkg;
  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int STARVE_W   = 4;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/gpr_wb_ctrl_scoreboard.sv
// Busy vector of registers with an outstanding MDU write, plus the RAW/WAW lookup for ID.
module gpr_scoreboard
  import gpr_wb_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic                  chk_valid,
  input  logic [REG_ADDR_W-1:0] chk_rs1,
  input  logic [REG_ADDR_W-1:0] chk_rs2,
  input  logic [REG_ADDR_W-1:0] chk_rd,
  input  logic                  chk_dest_wen,
  output logic                  stall
);
  logic [31:1] busy_q, busy_d;
  logic [31:0] busy_v;

  // x0 slot is hardwired clear so lookups need no special case
  assign busy_v = {busy_q, 1'b0};

  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < 32; i++) begin
      if (clr_en && clr_rd == REG_ADDR_W'(i)) busy_d[i] = 1'b0;
      if (set_en && set_rd == REG_ADDR_W'(i)) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign stall = chk_valid & (busy_v[chk_rs1] | busy_v[chk_rs2] |
                              (chk_dest_wen & busy_v[chk_rd]));
endmodule

// File: rtl/gpr_wb_ctrl.sv
// GPR write-port owner: arbitrates LS/WB writes against a one-entry MDU result buffer.
module gpr_wb_ctrl
  import gpr_wb_ctrl_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_dest_wen,
  input  logic                  id_long,
  input  logic                  id_fire,
  output logic                  id_stall,
  input  logic                  ls_valid,
  input  logic [REG_ADDR_W-1:0] ls_rd,
  input  logic                  ls_dest_wen,
  input  logic [XLEN-1:0]       ls_wdata,
  output logic                  ls_hold,
  input  logic                  mdu_valid,
  output logic                  mdu_ready,
  input  logic [REG_ADDR_W-1:0] mdu_rd,
  input  logic [XLEN-1:0]       mdu_wdata,
  output logic                  gpr_wen,
  output logic [REG_ADDR_W-1:0] gpr_rd,
  output logic [XLEN-1:0]       gpr_wdata
);
  wb_req_t               buf_q, buf_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic                  ls_hold_q, ls_hold_d;
  logic                  ls_req, buf_commit, lose;

  assign ls_req     = ls_valid & ls_dest_wen & (ls_rd != REG_X0) & ~ls_hold_q;
  assign buf_commit = buf_q.valid & (~ls_req | ls_hold_q);
  assign lose       = buf_q.valid & ~buf_commit;
  assign mdu_ready  = ~buf_q.valid | buf_commit;
  assign ls_hold    = ls_hold_q;

  always_comb begin
    gpr_wen   = 1'b0;
    gpr_rd    = buf_q.rd;
    gpr_wdata = buf_q.data;
    if (ls_req) begin
      gpr_wen   = 1'b1;
      gpr_rd    = ls_rd;
      gpr_wdata = ls_wdata;
    end else if (buf_commit) begin
      gpr_wen   = (buf_q.rd != REG_X0);
    end
    // LS pass-through is combinational, so reset must mask it explicitly
    if (rst) gpr_wen = 1'b0;
  end

  always_comb begin
    buf_d = buf_q;
    if (mdu_valid && mdu_ready) begin
      buf_d.valid = 1'b1;
      buf_d.rd    = mdu_rd;
      buf_d.data  = mdu_wdata;
    end else if (buf_commit) begin
      buf_d.valid = 1'b0;
    end
    starve_d  = lose ? starve_q + 1'b1 : '0;
    // Hold is raised on the edge where the loss count reaches STARVE_MAX-1
    ls_hold_d = lose && (starve_q == STARVE_W'(STARVE_MAX - 2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q     <= '0;
      starve_q  <= '0;
      ls_hold_q <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      starve_q  <= starve_d;
      ls_hold_q <= ls_hold_d;
    end
  end

  gpr_scoreboard u_sb (
    .clk          (clk),
    .rst          (rst),
    .set_en       (id_fire & id_long & id_dest_wen & (id_rd != REG_X0)),
    .set_rd       (id_rd),
    .clr_en       (buf_commit),
    .clr_rd       (buf_q.rd),
    .chk_valid    (id_valid),
    .chk_rs1      (id_rs1),
    .chk_rs2      (id_rs2),
    .chk_rd       (id_rd),
    .chk_dest_wen (id_dest_wen),
    .stall        (id_stall)
  );
endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Directed bench for gpr_wb_ctrl with a queue-based reference model checked every cycle.
module tb_gpr_wb_ctrl;
  localparam int XLEN = 64;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic id_valid, id_dest_wen, id_long, id_fire, id_stall;
  logic [4:0] id_rs1, id_rs2, id_rd, ls_rd, mdu_rd, gpr_rd;
  logic ls_valid, ls_dest_wen, ls_hold, mdu_valid, mdu_ready, gpr_wen;
  logic [XLEN-1:0] ls_wdata, mdu_wdata, gpr_wdata;

  int n_cmp = 0, n_bad = 0;

  gpr_wb_ctrl #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_dest_wen(id_dest_wen), .id_long(id_long), .id_fire(id_fire), .id_stall(id_stall),
    .ls_valid(ls_valid), .ls_rd(ls_rd), .ls_dest_wen(ls_dest_wen), .ls_wdata(ls_wdata),
    .ls_hold(ls_hold), .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd),
    .mdu_wdata(mdu_wdata), .gpr_wen(gpr_wen), .gpr_rd(gpr_rd), .gpr_wdata(gpr_wdata)
  );

  always #5 clk = ~clk;

  // Reference model: pending MDU results as a queue, busy as a flag per register
  typedef struct { logic [4:0] rd; logic [63:0] data; } ent_t;
  ent_t pend[$];
  bit   busy_m[32];
  int   lose_run = 0;
  bit   hold_m = 0;

  typedef struct { bit stall, ready, hold, wen, commit, lose; logic [4:0] rd; logic [63:0] data; } exp_t;

  function automatic exp_t mdl_eval();
    exp_t e;
    bit ls_wins;
    ls_wins  = ls_valid && ls_dest_wen && ls_rd != 0 && !hold_m;
    e.commit = pend.size() > 0 && !ls_wins;
    e.lose   = pend.size() > 0 && !e.commit;
    e.ready  = pend.size() == 0 || e.commit;
    e.hold   = hold_m;
    e.stall  = id_valid && (busy_m[id_rs1] || busy_m[id_rs2] || (id_dest_wen && busy_m[id_rd]));
    e.wen = 0; e.rd = 0; e.data = 0;
    if (ls_wins) begin
      e.wen = 1; e.rd = ls_rd; e.data = ls_wdata;
    end else if (e.commit) begin
      e.wen = pend[0].rd != 0; e.rd = pend[0].rd; e.data = pend[0].data;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        foreach (busy_m[i]) busy_m[i] = 0;
        pend.delete(); lose_run = 0; hold_m = 0;
      end else begin
        exp_t e;
        e = mdl_eval();
        if (e.commit) begin busy_m[pend[0].rd] = 0; void'(pend.pop_front()); end
        if (id_fire && id_long && id_dest_wen && id_rd != 0) busy_m[id_rd] = 1;
        if (mdu_valid && e.ready) pend.push_back('{mdu_rd, mdu_wdata});
        if (e.lose) begin lose_run++; hold_m = (lose_run == STARVE_MAX - 1); end
        else begin lose_run = 0; hold_m = 0; end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_t e;
        e = mdl_eval();
        chk("cyc_id_stall", 64'(id_stall), 64'(e.stall));
        chk("cyc_mdu_ready", 64'(mdu_ready), 64'(e.ready));
        chk("cyc_ls_hold", 64'(ls_hold), 64'(e.hold));
        chk("cyc_gpr_wen", 64'(gpr_wen), 64'(e.wen));
        if (e.wen) begin
          chk("cyc_gpr_rd", 64'(gpr_rd), 64'(e.rd));
          chk("cyc_gpr_wdata", gpr_wdata, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_dest_wen = 0; id_long = 0; id_fire = 0;
    ls_valid = 0; ls_rd = 0; ls_dest_wen = 0; ls_wdata = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_wdata = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic fire_long(input logic [4:0] rd);
    id_valid = 1; id_long = 1; id_dest_wen = 1; id_rd = rd; id_fire = 1;
  endtask

  initial begin
    idle();
    ls_valid = 1; ls_dest_wen = 1; ls_rd = 5; ls_wdata = 64'h55;
    #2;
    chk("rst_gpr_wen", 64'(gpr_wen), 64'd0);
    chk("rst_mdu_ready", 64'(mdu_ready), 64'd1);
    chk("rst_id_stall", 64'(id_stall), 64'd0);
    chk("rst_ls_hold", 64'(ls_hold), 64'd0);
    #15 rst = 0; idle();

    // LS pass-through, then rd=0 suppressed
    step(); ls_valid = 1; ls_dest_wen = 1; ls_rd = 5; ls_wdata = 64'h1234;
    @(negedge clk);
    chk("pt_wen", 64'(gpr_wen), 64'd1);
    chk("pt_rd", 64'(gpr_rd), 64'd5);
    chk("pt_data", gpr_wdata, 64'h1234);
    step(); ls_rd = 0;
    @(negedge clk); chk("pt_x0_wen", 64'(gpr_wen), 64'd0);
    step(); idle();

    // MDU result with LS idle commits the next cycle
    mdu_valid = 1; mdu_rd = 9; mdu_wdata = 64'hDEAD;
    @(negedge clk);
    chk("mdu_acc_ready", 64'(mdu_ready), 64'd1);
    chk("mdu_acc_wen", 64'(gpr_wen), 64'd0);
    step(); mdu_valid = 0;
    @(negedge clk);
    chk("mdu_cm_wen", 64'(gpr_wen), 64'd1);
    chk("mdu_cm_rd", 64'(gpr_rd), 64'd9);
    chk("mdu_cm_data", gpr_wdata, 64'hDEAD);
    chk("mdu_cm_ready", 64'(mdu_ready), 64'd1);
    step(); @(negedge clk); chk("mdu_after_wen", 64'(gpr_wen), 64'd0);

    // RAW/WAW stall against a pending long op on x7
    step(); fire_long(7);
    @(negedge clk); chk("raw_fire_stall", 64'(id_stall), 64'd0);
    step(); id_fire = 0; id_long = 0; id_rd = 1; id_rs1 = 7;
    @(negedge clk); chk("raw_rs1", 64'(id_stall), 64'd1);
    step(); id_rs1 = 0; id_rs2 = 7;
    @(negedge clk); chk("raw_rs2", 64'(id_stall), 64'd1);
    step(); id_rs2 = 0; id_rd = 7;
    @(negedge clk); chk("waw_rd", 64'(id_stall), 64'd1);
    step(); id_rd = 0;
    @(negedge clk); chk("x0_nostall", 64'(id_stall), 64'd0);
    step(); id_rs1 = 7; mdu_valid = 1; mdu_rd = 7; mdu_wdata = 64'h77;
    @(negedge clk); chk("raw_acc_stall", 64'(id_stall), 64'd1);
    step(); mdu_valid = 0;
    @(negedge clk);
    chk("raw_cm_stall", 64'(id_stall), 64'd1);
    chk("raw_cm_rd", 64'(gpr_rd), 64'd7);
    step(); @(negedge clk); chk("raw_released", 64'(id_stall), 64'd0);
    step(); idle();

    // Contention: LS writes every cycle while buffer holds x12 result
    fire_long(12);
    step(); id_fire = 0; id_long = 0; id_rd = 0; id_rs1 = 12;
    ls_valid = 1; ls_dest_wen = 1; ls_rd = 3; ls_wdata = 64'h3000;
    mdu_valid = 1; mdu_rd = 12; mdu_wdata = 64'hC0DE;
    @(negedge clk);
    chk("ct_acc_rd", 64'(gpr_rd), 64'd3);
    chk("ct_acc_stall", 64'(id_stall), 64'd1);
    step(); mdu_valid = 0;
    for (int k = 1; k <= 3; k++) begin
      ls_wdata = 64'h3000 + 64'(k);
      @(negedge clk);
      chk("ct_lose_hold", 64'(ls_hold), 64'd0);
      chk("ct_lose_rd", 64'(gpr_rd), 64'd3);
      chk("ct_lose_ready", 64'(mdu_ready), 64'd0);
      step();
    end
    @(negedge clk);
    chk("ct_hold", 64'(ls_hold), 64'd1);
    chk("ct_hold_rd", 64'(gpr_rd), 64'd12);
    chk("ct_hold_data", gpr_wdata, 64'hC0DE);
    chk("ct_hold_ready", 64'(mdu_ready), 64'd1);
    step(); @(negedge clk);
    chk("ct_replay_hold", 64'(ls_hold), 64'd0);
    chk("ct_replay_data", gpr_wdata, 64'h3003);
    chk("ct_replay_stall", 64'(id_stall), 64'd0);
    step(); idle();

    // Back-to-back MDU results
    mdu_valid = 1; mdu_rd = 20; mdu_wdata = 64'hA;
    step(); mdu_rd = 21; mdu_wdata = 64'hB;
    @(negedge clk);
    chk("b2b_ready", 64'(mdu_ready), 64'd1);
    chk("b2b_first_rd", 64'(gpr_rd), 64'd20);
    step(); mdu_valid = 0;
    @(negedge clk);
    chk("b2b_second_rd", 64'(gpr_rd), 64'd21);
    chk("b2b_second_data", gpr_wdata, 64'hB);
    step(); idle();

    // Asynchronous reset with buffer full and x3/x12 busy
    fire_long(3);
    step(); id_rd = 12;
    step(); idle(); ls_valid = 1; ls_dest_wen = 1; ls_rd = 5; ls_wdata = 64'h5;
    mdu_valid = 1; mdu_rd = 3; mdu_wdata = 64'h33;
    step(); mdu_valid = 0; id_valid = 1; id_rs1 = 3; id_rs2 = 12;
    @(negedge clk);
    chk("mr_pre_stall", 64'(id_stall), 64'd1);
    chk("mr_pre_ready", 64'(mdu_ready), 64'd0);
    #2 rst = 1;
    #1;
    chk("mr_rst_wen", 64'(gpr_wen), 64'd0);
    chk("mr_rst_ready", 64'(mdu_ready), 64'd1);
    chk("mr_rst_stall", 64'(id_stall), 64'd0);
    chk("mr_rst_hold", 64'(ls_hold), 64'd0);
    #1 rst = 0;
    @(negedge clk);
    chk("mr_post_stall", 64'(id_stall), 64'd0);
    chk("mr_post_ls_wen", 64'(gpr_wen), 64'd1);
    step(); ls_valid = 0;
    @(negedge clk); chk("mr_buf_dropped", 64'(gpr_wen), 64'd0);
    step(); idle();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
